// File: rtl/shift_reg_universal_if.sv
// ============================================================================
// Module   : shift_reg_universal_if
// Brief    : Control/data bundle for the universal shift register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_reg_universal_if #(
   parameter int WIDTH = 4,
   parameter int AMT_W = $clog2(WIDTH) + 1
);
   logic             load;
   logic [WIDTH-1:0] i;
   logic             start;
   logic [1:0]       mode;
   logic [AMT_W-1:0] amount;
   logic             sin;
   logic [WIDTH-1:0] q;
   logic             sout;
   logic             busy;
   logic             done;

   modport master (
      output load, i, start, mode, amount, sin,
      input  q, sout, busy, done
   );

   modport slave (
      input  load, i, start, mode, amount, sin,
      output q, sout, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/shift_reg_universal.sv
// ============================================================================
// Module   : shift_reg_universal
// Brief    : Parametrised universal shift register, one bit per clock under a
//            start/busy/done handshake. SHIFT_REG_SERIAL_IN_EN selects sin as
//            the SLL/SRL fill bit (default build fills with 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_universal #(
   parameter int WIDTH = 4,
   parameter int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic                  c,
   input  logic                  rst_n,
   shift_reg_universal_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [1:0]       c_MODE_SLL = 2'b00;
   localparam logic [1:0]       c_MODE_SRL = 2'b01;
   localparam logic [1:0]       c_MODE_ROL = 2'b10;
   localparam logic [1:0]       c_MODE_ROR = 2'b11;
   localparam logic [AMT_W-1:0] c_CNT_ZERO = '0;
   localparam logic [AMT_W-1:0] c_CNT_ONE  = AMT_W'(1);

   state_t           r_state;
   logic [WIDTH-1:0] r_q;
   logic             r_sout;
   logic             r_busy;
   logic             r_done;
   logic [AMT_W-1:0] r_cnt;
   logic [1:0]       r_mode;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_q_nxt;
   logic             w_sout_nxt;
   logic [AMT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_mode_nxt;
   logic [WIDTH-1:0] w_step_q;
   logic             w_step_out;
   logic             w_fill;

`ifdef SHIFT_REG_SERIAL_IN_EN
   assign w_fill = bus.sin;
`else
   logic w_unused_sin;
   assign w_fill       = 1'b0;
   assign w_unused_sin = bus.sin;
`endif

   // Single-step result for the latched mode; applied only in SHIFT.
   always_comb begin
      w_step_q   = r_q;
      w_step_out = r_sout;
      case (r_mode)
         c_MODE_SLL: begin
            w_step_q   = {r_q[WIDTH-2:0], w_fill};
            w_step_out = r_q[WIDTH-1];
         end
         c_MODE_SRL: begin
            w_step_q   = {w_fill, r_q[WIDTH-1:1]};
            w_step_out = r_q[0];
         end
         c_MODE_ROL: begin
            w_step_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            w_step_out = r_q[WIDTH-1];
         end
         c_MODE_ROR: begin
            w_step_q   = {r_q[0], r_q[WIDTH-1:1]};
            w_step_out = r_q[0];
         end
         default: begin
            w_step_q   = r_q;
            w_step_out = r_sout;
         end
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_sout_nxt  = r_sout;
      w_cnt_nxt   = r_cnt;
      w_mode_nxt  = r_mode;
      case (r_state)
         S_IDLE: begin
            if (bus.load) begin
               w_q_nxt = bus.i;
            end else if (bus.start) begin
               w_mode_nxt  = bus.mode;
               w_cnt_nxt   = bus.amount;
               w_state_nxt = (bus.amount == c_CNT_ZERO) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_q_nxt    = w_step_q;
            w_sout_nxt = w_step_out;
            w_cnt_nxt  = r_cnt - c_CNT_ONE;
            if (r_cnt == c_CNT_ONE) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // busy/done are decoded from the next state so they leave as flop outputs.
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_sout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         r_mode  <= c_MODE_SLL;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_sout  <= w_sout_nxt;
         r_busy  <= (w_state_nxt == S_SHIFT);
         r_done  <= (w_state_nxt == S_DONE);
         r_cnt   <= w_cnt_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

   assign bus.q    = r_q;
   assign bus.sout = r_sout;
   assign bus.busy = r_busy;
   assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_universal.sv
// ============================================================================
// Module   : tb_shift_reg_universal
// Brief    : Scoreboard bench for shift_reg_universal (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_universal;

   localparam int c_WIDTH = 4;
   localparam int c_AMT_W = 3;

   typedef struct {
      int         id;
      logic [3:0] q;
      logic       sout;
      int         busy_cycles;
   } exp_t;

   logic c;
   logic rst_n;
   exp_t sb[$];
   int   n_checks;
   int   n_pass;
   int   op_id;
   int   busy_cnt;

   shift_reg_universal_if #(.WIDTH(c_WIDTH), .AMT_W(c_AMT_W)) bus ();

   shift_reg_universal #(.WIDTH(c_WIDTH), .AMT_W(c_AMT_W)) dut (
      .c     (c),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: pops one expectation per done pulse.
   initial begin
      exp_t e;
      busy_cnt = 0;
      forever begin
         @(negedge c);
         if (!rst_n) begin
            busy_cnt = 0;
         end else begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("q op%0d", e.id), 32'(bus.q), 32'(e.q));
                  chk($sformatf("sout op%0d", e.id), 32'(bus.sout), 32'(e.sout));
                  chk($sformatf("busy_cycles op%0d", e.id), 32'(busy_cnt), 32'(e.busy_cycles));
               end
               busy_cnt = 0;
            end
         end
      end
   end

   task automatic do_load(input logic [3:0] d);
      @(negedge c);
      bus.load = 1'b1;
      bus.i    = d;
      @(negedge c);
      bus.load = 1'b0;
      chk("load_q", 32'(bus.q), 32'(d));
      chk("load_busy", 32'(bus.busy), 32'd0);
   endtask

   // Returns at the negedge following the start edge.
   task automatic start_op(input logic [1:0] m, input logic [2:0] amt, input bit push,
                           input logic [3:0] eq, input logic es, input int eb);
      exp_t e;
      @(negedge c);
      bus.start  = 1'b1;
      bus.mode   = m;
      bus.amount = amt;
      if (push) begin
         op_id++;
         e.id = op_id; e.q = eq; e.sout = es; e.busy_cycles = eb;
         sb.push_back(e);
      end
      @(negedge c);
      bus.start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge c);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; op_id = 0;
      rst_n = 1'b0;
      bus.load = 1'b0; bus.i = '0; bus.start = 1'b0;
      bus.mode = 2'b00; bus.amount = '0; bus.sin = 1'b0;
      repeat (2) @(negedge c);
      rst_n = 1'b1;

      // Asynchronous reset with a non-zero register
      do_load(4'b1010);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_q", 32'(bus.q), 32'd0);
      chk("async_rst_busy", 32'(bus.busy), 32'd0);
      chk("async_rst_done", 32'(bus.done), 32'd0);
      chk("async_rst_sout", 32'(bus.sout), 32'd0);
      @(negedge c);
      rst_n = 1'b1;

      // SLL by 2 with per-step observation
      do_load(4'b0011);
      start_op(2'b00, 3'd2, 1'b1, 4'b1100, 1'b0, 2);
      chk("sll_start_no_shift", 32'(bus.q), 32'b0011);
      chk("sll_busy", 32'(bus.busy), 32'd1);
      @(negedge c);
      chk("sll_step1", 32'(bus.q), 32'b0110);
      wait_done();

      // SRL by 3: 1100 -> 0110 -> 0011 -> 0001
      start_op(2'b01, 3'd3, 1'b1, 4'b0001, 1'b1, 3);
      wait_done();

      // ROR by 1
      do_load(4'b0011);
      start_op(2'b11, 3'd1, 1'b1, 4'b1001, 1'b1, 1);
      wait_done();

      // ROL by WIDTH returns to the same value
      start_op(2'b10, 3'd4, 1'b1, 4'b1001, 1'b1, 4);
      wait_done();

      // amount=0: done the cycle after start, no busy, q and sout held
      start_op(2'b00, 3'd0, 1'b1, 4'b1001, 1'b1, 0);
      chk("amt0_done", 32'(bus.done), 32'd1);
      chk("amt0_busy", 32'(bus.busy), 32'd0);

      // load and start together: load wins, start dropped
      @(negedge c);
      bus.load = 1'b1; bus.i = 4'b0101;
      bus.start = 1'b1; bus.mode = 2'b00; bus.amount = 3'd2;
      @(negedge c);
      bus.load = 1'b0; bus.start = 1'b0;
      chk("prio_q", 32'(bus.q), 32'b0101);
      chk("prio_busy", 32'(bus.busy), 32'd0);
      @(negedge c);
      chk("prio_busy_later", 32'(bus.busy), 32'd0);
      chk("prio_done", 32'(bus.done), 32'd0);

      // Inputs changed while busy are ignored: 0101 -> 1010 -> 0100
      start_op(2'b00, 3'd2, 1'b1, 4'b0100, 1'b1, 2);
      bus.load = 1'b1; bus.i = 4'b1111; bus.mode = 2'b11; bus.amount = 3'd7;
      bus.start = 1'b1;
      wait_done();
      bus.load = 1'b0; bus.start = 1'b0;
      @(negedge c);
      chk("ignore_q_after", 32'(bus.q), 32'b0100);

      // amount > WIDTH: SRL by 5 drains to zero, last bit out is 0
      start_op(2'b01, 3'd5, 1'b1, 4'b0000, 1'b0, 5);
      wait_done();

      // Abort during second step of SLL by 3
      do_load(4'b0001);
      start_op(2'b00, 3'd3, 1'b0, 4'b0000, 1'b0, 0);
      @(negedge c);
      chk("abort_step1", 32'(bus.q), 32'b0010);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_q", 32'(bus.q), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      repeat (3) begin
         @(negedge c);
         chk("abort_no_done", 32'(bus.done), 32'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge c);
      chk("post_abort_done", 32'(bus.done), 32'd0);

`ifdef SHIFT_REG_SERIAL_IN_EN
      // Serial-in deserialise 1,0,1,1 into an empty register
      do_load(4'b0000);
      start_op(2'b00, 3'd4, 1'b1, 4'b1011, 1'b0, 4);
      bus.sin = 1'b1;
      @(negedge c);
      bus.sin = 1'b0;
      @(negedge c);
      bus.sin = 1'b1;
      @(negedge c);
      bus.sin = 1'b1;
      wait_done();
      bus.sin = 1'b0;
`endif

      repeat (3) @(negedge c);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
